vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Dual-mode VGA raster timing generator. Runs off the pixel clock and produces
//  the horizontal/vertical position, sync, blanking, and end-of-line/frame strobes
//  that drive the scene renderer and the clock overlay. All outputs are registered
//  and describe the same pixel on any given cycle. Mode 0 is 640x480@60
//  (25.175 MHz); mode 1 is 640x480@72 (31.5 MHz).
// PARAMETERS
//  SYNC_ACTIVE_LOW  1  1: o_hsync/o_vsync idle high, pulse low; 0: inverted
//  FRAME_CNT_W      8  width of o_frame free-running frame counter
// PORTS
//  clk        in   1   pixel clock; all logic on rising edge
//  rst_n      in   1   synchronous reset, active low
//  mode       in   1   timing select (0=VGA60, 1=VGA72); takes effect at frame end only
//  o_hsync    out  1   horizontal sync
//  o_vsync    out  1   vertical sync
//  o_hpos     out  10  current pixel column, 0..HTOTAL-1
//  o_vpos     out  10  current line, 0..VTOTAL-1
//  o_hmax     out  1   high when o_hpos==HTOTAL-1
//  o_vmax     out  1   high when o_vpos==VTOTAL-1
//  o_hblank   out  1   high when o_hpos>=640
//  o_vblank   out  1   high when o_vpos>=480
//  o_visible  out  1   ~o_hblank & ~o_vblank
//  o_frame    out  FRAME_CNT_W  frames completed since reset, wraps
// BEHAVIOUR
//  Reset: clk and rst_n are the only clock/reset. Reset is synchronous and
//   active-low. On a rising edge with rst_n==0: hpos=0, vpos=0, frame=0, and the
//   active mode register loads the mode input. Outputs then show pixel (0,0):
//   visible=1, hblank=vblank=0, hmax=vmax=0, syncs inactive. Reset mid-line or
//   mid-frame aborts immediately, with no completion of the current line.
//  Timing table (H visible/front/sync/back = total; V likewise):
//   mode0 H 640/16/96/48=800  V 480/10/2/33=525
//   mode1 H 640/24/40/128=832 V 480/9/3/28=520
//  Horizontal: hpos increments every cycle. At hmax it wraps to 0 on the next
//   cycle.
//  Vertical: vpos increments only on cycles where hmax=1. At hmax&vmax it wraps
//   to 0, and frame increments (mod 2^FRAME_CNT_W).
//  Sync: hsync is active for hpos in [640+HFP, 640+HFP+HSYNC). For mode0 this is
//   656..751; for mode1 it is 664..703. vsync is active for vpos in
//   [480+VFP, 480+VFP+VSYNC). For mode0 this is 490..491; for mode1 it is
//   489..491. Active level is set by SYNC_ACTIVE_LOW.
//  Registering: every flag is registered and computed from the next-state counter
//   value, so flags and o_hpos/o_vpos are cycle-aligned (zero relative latency).
//   Outputs carry no combinational path from inputs.
//  Mode switch: mode is sampled into the active mode register only on the cycle
//   where hmax&vmax=1. The first pixel of the next frame already uses the new
//   table. A mid-frame toggle of mode has no effect on the current frame. A
//   pulse that returns to the original value before frame end is ignored.
//  Consumer contract: frame_end = hmax&vmax is high for exactly one cycle per
//   frame. hmax is high for exactly one cycle per line.
//  Counter width: 10 bits suffices, since max HTOTAL is 832 and max VTOTAL is 525.
//   Counters never exceed TOTAL-1 in either mode, including the cycle of a switch.
// STRUCTURE
//  Shared package vga_timing_pkg holds:
//   - per-mode localparams H/V visible, front porch, sync, back porch, and total
//   - mode encoding constants VGA60=0, VGA72=1
//  One sub-module, vga_axis_counter, is instantiated twice (H and V).
//   - Ports: clk, rst_n, inc, total/sync_start/sync_end/vis_end (10b each), pos,
//     max, blank, sync.
//   - The parent muxes the thresholds from the active mode register.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clocks, release. Expect hpos=0, vpos=0,
//    visible=1, hsync=vsync=1, frame=0. hpos=1 one cycle after release.
//  2 Mode0 line: count clocks between hmax pulses -> 800. hsync low exactly at
//    hpos 656..751 (96 clocks). hblank rises at hpos=640.
//  3 Mode0 frame: hmax&vmax every 420000 clocks. vsync low on lines 490-491.
//    frame increments 0->1 at the first wrap.
//  4 Mode1 from reset: line length 832, hsync at 664..703. Frame 520 lines,
//    vsync on lines 489-491.
//  5 Mid-frame switch: set mode 0->1 at vpos=200. Frame completes at 800x525.
//    The next frame uses 832x520. Toggle 0->1->0 within one frame -> no change.
//  6 Reset mid-frame at hpos=300, vpos=300: the cycle after release shows hpos=1,
//    vpos=0, frame=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing tables for the two supported 640x480 modes and the
// helpers that turn a mode into per-axis counter thresholds.
package vga_timing_pkg;

    localparam int unsigned POS_W = 10;

    typedef enum logic {
        VGA60 = 1'b0,
        VGA72 = 1'b1
    } vga_mode_e;

    localparam int unsigned H_VIS = 640;
    localparam int unsigned V_VIS = 480;

    localparam int unsigned M0_H_FP    = 16;
    localparam int unsigned M0_H_SYNC  = 96;
    localparam int unsigned M0_H_BP    = 48;
    localparam int unsigned M0_H_TOTAL = H_VIS + M0_H_FP + M0_H_SYNC + M0_H_BP;
    localparam int unsigned M0_V_FP    = 10;
    localparam int unsigned M0_V_SYNC  = 2;
    localparam int unsigned M0_V_BP    = 33;
    localparam int unsigned M0_V_TOTAL = V_VIS + M0_V_FP + M0_V_SYNC + M0_V_BP;

    localparam int unsigned M1_H_FP    = 24;
    localparam int unsigned M1_H_SYNC  = 40;
    localparam int unsigned M1_H_BP    = 128;
    localparam int unsigned M1_H_TOTAL = H_VIS + M1_H_FP + M1_H_SYNC + M1_H_BP;
    localparam int unsigned M1_V_FP    = 9;
    localparam int unsigned M1_V_SYNC  = 3;
    localparam int unsigned M1_V_BP    = 28;
    localparam int unsigned M1_V_TOTAL = V_VIS + M1_V_FP + M1_V_SYNC + M1_V_BP;

    typedef struct packed {
        logic [POS_W-1:0] total;
        logic [POS_W-1:0] sync_start;
        logic [POS_W-1:0] sync_end;
        logic [POS_W-1:0] vis_end;
    } axis_cfg_t;

    function automatic axis_cfg_t h_cfg(input vga_mode_e m);
        axis_cfg_t c;
        c.vis_end = POS_W'(H_VIS);
        if (m == VGA72) begin
            c.sync_start = POS_W'(H_VIS + M1_H_FP);
            c.sync_end   = POS_W'(H_VIS + M1_H_FP + M1_H_SYNC);
            c.total      = POS_W'(M1_H_TOTAL);
        end else begin
            c.sync_start = POS_W'(H_VIS + M0_H_FP);
            c.sync_end   = POS_W'(H_VIS + M0_H_FP + M0_H_SYNC);
            c.total      = POS_W'(M0_H_TOTAL);
        end
        return c;
    endfunction

    function automatic axis_cfg_t v_cfg(input vga_mode_e m);
        axis_cfg_t c;
        c.vis_end = POS_W'(V_VIS);
        if (m == VGA72) begin
            c.sync_start = POS_W'(V_VIS + M1_V_FP);
            c.sync_end   = POS_W'(V_VIS + M1_V_FP + M1_V_SYNC);
            c.total      = POS_W'(M1_V_TOTAL);
        end else begin
            c.sync_start = POS_W'(V_VIS + M0_V_FP);
            c.sync_end   = POS_W'(V_VIS + M0_V_FP + M0_V_SYNC);
            c.total      = POS_W'(M0_V_TOTAL);
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered max/blank/sync
// flags derived from the next position so they align with pos.
module vga_axis_counter
    import vga_timing_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [POS_W-1:0] total,
    input  logic [POS_W-1:0] sync_start,
    input  logic [POS_W-1:0] sync_end,
    input  logic [POS_W-1:0] vis_end,
    output logic [POS_W-1:0] pos,
    output logic             max,
    output logic             blank,
    output logic             sync
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             max_q, max_d;
    logic             blank_q, blank_d;
    logic             sync_q, sync_d;

    // Thresholds must already reflect the mode that applies to pos_d.
    always_comb begin
        pos_d = pos_q;
        if (inc) begin
            pos_d = max_q ? '0 : pos_q + POS_W'(1);
        end
        max_d   = (pos_d == total - POS_W'(1));
        blank_d = (pos_d >= vis_end);
        sync_d  = (pos_d >= sync_start) && (pos_d < sync_end);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q   <= '0;
            max_q   <= 1'b0;
            blank_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            max_q   <= max_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign pos   = pos_q;
    assign max   = max_q;
    assign blank = blank_q;
    assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Dual-mode 640x480 raster timing generator (60 Hz / 72 Hz); mode changes
// are latched only at frame end so a frame never mixes timing tables.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter logic        SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned FRAME_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic [9:0]             o_hpos,
    output logic [9:0]             o_vpos,
    output logic                   o_hmax,
    output logic                   o_vmax,
    output logic                   o_hblank,
    output logic                   o_vblank,
    output logic                   o_visible,
    output logic [FRAME_CNT_W-1:0] o_frame
);

    vga_mode_e              mode_q, mode_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    axis_cfg_t              h_cfg_sel, v_cfg_sel;
    logic [POS_W-1:0]       h_pos, v_pos;
    logic                   h_max, v_max, h_blank, v_blank, h_sync, v_sync;
    logic                   frame_end;

    assign frame_end = h_max & v_max;

    // Thresholds follow the next mode so the first pixel of a new frame
    // is already flagged against the new table.
    always_comb begin
        mode_d  = mode_q;
        frame_d = frame_q;
        if (frame_end) begin
            mode_d  = vga_mode_e'(mode);
            frame_d = frame_q + FRAME_CNT_W'(1);
        end
        h_cfg_sel = h_cfg(mode_d);
        v_cfg_sel = v_cfg(mode_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= vga_mode_e'(mode);
            frame_q <= '0;
        end else begin
            mode_q  <= mode_d;
            frame_q <= frame_d;
        end
    end

    vga_axis_counter u_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (1'b1),
        .total      (h_cfg_sel.total),
        .sync_start (h_cfg_sel.sync_start),
        .sync_end   (h_cfg_sel.sync_end),
        .vis_end    (h_cfg_sel.vis_end),
        .pos        (h_pos),
        .max        (h_max),
        .blank      (h_blank),
        .sync       (h_sync)
    );

    vga_axis_counter u_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (h_max),
        .total      (v_cfg_sel.total),
        .sync_start (v_cfg_sel.sync_start),
        .sync_end   (v_cfg_sel.sync_end),
        .vis_end    (v_cfg_sel.vis_end),
        .pos        (v_pos),
        .max        (v_max),
        .blank      (v_blank),
        .sync       (v_sync)
    );

    assign o_hsync   = h_sync ^ SYNC_ACTIVE_LOW;
    assign o_vsync   = v_sync ^ SYNC_ACTIVE_LOW;
    assign o_hpos    = h_pos;
    assign o_vpos    = v_pos;
    assign o_hmax    = h_max;
    assign o_vmax    = v_max;
    assign o_hblank  = h_blank;
    assign o_vblank  = v_blank;
    assign o_visible = ~h_blank & ~v_blank;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: reset, line/frame timing in both modes,
// frame-end-only mode switching and mid-frame reset.
module tb_vga_timing_gen;

    localparam int H0 = 800;
    localparam int V0 = 525;
    localparam int H1 = 832;
    localparam int V1 = 520;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode  = 1'b0;
    logic       o_hsync, o_vsync, o_hmax, o_vmax, o_hblank, o_vblank, o_visible;
    logic [9:0] o_hpos, o_vpos;
    logic [7:0] o_frame;

    int checks = 0;
    int errors = 0;

    // Reference raster position of the pixel currently shown.
    int         e_h = 0;
    int         e_v = 0;
    logic [7:0] e_f = '0;
    logic       e_mode = 1'b0;
    int         cyc = 0;
    int         mm_pos = 0, mm_flag = 0, mm_sync = 0, mm_frame = 0;

    vga_timing_gen #(
        .SYNC_ACTIVE_LOW (1'b1),
        .FRAME_CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .o_hsync   (o_hsync),
        .o_vsync   (o_vsync),
        .o_hpos    (o_hpos),
        .o_vpos    (o_vpos),
        .o_hmax    (o_hmax),
        .o_vmax    (o_vmax),
        .o_hblank  (o_hblank),
        .o_vblank  (o_vblank),
        .o_visible (o_visible),
        .o_frame   (o_frame)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic m, input int n);
        rst_n = 1'b0;
        mode  = m;
        repeat (n) @(negedge clk);
        rst_n  = 1'b1;
        e_h    = 0;
        e_v    = 0;
        e_f    = '0;
        e_mode = m;
        cyc    = 0;
    endtask

    // Advance one pixel per cycle and tally any disagreement with the table.
    task automatic run_cycles(input int n);
        int   ht, vt, hss, hse, vss;
        logic xh, xv;
        for (int i = 0; i < n; i++) begin
            ht = e_mode ? H1 : H0;
            vt = e_mode ? V1 : V0;
            if (e_h == ht - 1) begin
                e_h = 0;
                if (e_v == vt - 1) begin
                    e_v    = 0;
                    e_f    = e_f + 8'd1;
                    e_mode = mode;
                end else begin
                    e_v++;
                end
            end else begin
                e_h++;
            end
            @(negedge clk);
            cyc++;
            ht  = e_mode ? H1 : H0;
            vt  = e_mode ? V1 : V0;
            hss = e_mode ? 664 : 656;
            hse = e_mode ? 704 : 752;
            vss = e_mode ? 489 : 490;
            xh  = !(e_h >= hss && e_h < hse);
            xv  = !(e_v >= vss && e_v < 492);
            if (o_hpos !== 10'(e_h) || o_vpos !== 10'(e_v)) mm_pos++;
            if (o_hmax !== (e_h == ht - 1) || o_vmax !== (e_v == vt - 1) ||
                o_hblank !== (e_h >= 640) || o_vblank !== (e_v >= 480) ||
                o_visible !== (e_h < 640 && e_v < 480)) mm_flag++;
            if (o_hsync !== xh || o_vsync !== xv) mm_sync++;
            if (o_frame !== e_f) mm_frame++;
        end
    endtask

    task automatic test_reset;
        do_reset(1'b0, 3);
        checks++;
        if (o_hpos !== 10'd0 || o_vpos !== 10'd0) begin
            errors++;
            $display("FAIL reset_pos: hpos=%0d vpos=%0d, required 0/0", o_hpos, o_vpos);
        end
        checks++;
        if (o_visible !== 1'b1 || o_hblank !== 1'b0 || o_vblank !== 1'b0 ||
            o_hmax !== 1'b0 || o_vmax !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: vis=%b hb=%b vb=%b hmax=%b vmax=%b, required 1/0/0/0/0",
                     o_visible, o_hblank, o_vblank, o_hmax, o_vmax);
        end
        checks++;
        if (o_hsync !== 1'b1 || o_vsync !== 1'b1) begin
            errors++;
            $display("FAIL reset_sync: hsync=%b vsync=%b, required 1/1", o_hsync, o_vsync);
        end
        checks++;
        if (o_frame !== 8'd0) begin
            errors++;
            $display("FAIL reset_frame: frame=%0d, required 0", o_frame);
        end
        run_cycles(1);
        checks++;
        if (o_hpos !== 10'd1) begin
            errors++;
            $display("FAIL reset_release: hpos=%0d, required 1", o_hpos);
        end
    endtask

    task automatic test_mode0_line;
        int len = 0, hs_cnt = 0, hs_first = -1, hb_first = -1;
        for (int t = 0; t < 1000 && o_hmax !== 1'b1; t++) run_cycles(1);
        checks++;
        if (o_hmax !== 1'b1) begin
            errors++;
            $display("FAIL m0_first_hmax: hmax=%b after 1000 cycles, required 1", o_hmax);
        end
        for (int t = 0; t < 1000; t++) begin
            run_cycles(1);
            len++;
            if (o_hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(o_hpos);
            end
            if (o_hblank === 1'b1 && hb_first < 0) hb_first = int'(o_hpos);
            if (o_hmax === 1'b1) break;
        end
        checks++;
        if (len != 800) begin
            errors++;
            $display("FAIL m0_line_len: %0d clocks, required 800", len);
        end
        checks++;
        if (hs_cnt != 96 || hs_first != 656) begin
            errors++;
            $display("FAIL m0_hsync: %0d clocks from hpos %0d, required 96 from 656", hs_cnt, hs_first);
        end
        checks++;
        if (hb_first != 640) begin
            errors++;
            $display("FAIL m0_hblank: rises at hpos %0d, required 640", hb_first);
        end
    endtask

    // Frame 0 runs at VGA60; a 0->1->0 pulse and a later 0->1 request at
    // line 200 must both leave this frame at 800x525.
    task automatic test_mode0_frame_switch;
        int vs_min = 1000, vs_max = -1, fe_cyc = -1;
        logic [7:0] fr_end = 8'hff;
        for (int t = 0; t < 430000; t++) begin
            run_cycles(1);
            if (o_hpos == 10'd0) begin
                if (o_vpos == 10'd50)  mode = 1'b1;
                if (o_vpos == 10'd60)  mode = 1'b0;
                if (o_vpos == 10'd200) mode = 1'b1;
            end
            if (o_vsync === 1'b0) begin
                if (int'(o_vpos) < vs_min) vs_min = int'(o_vpos);
                if (int'(o_vpos) > vs_max) vs_max = int'(o_vpos);
            end
            if (o_hmax === 1'b1 && o_vmax === 1'b1) begin
                fe_cyc = cyc;
                fr_end = o_frame;
                break;
            end
        end
        checks++;
        if (fe_cyc != 419999) begin
            errors++;
            $display("FAIL m0_frame_len: frame end at cycle %0d, required 419999", fe_cyc);
        end
        checks++;
        if (vs_min != 490 || vs_max != 491) begin
            errors++;
            $display("FAIL m0_vsync: lines %0d..%0d, required 490..491", vs_min, vs_max);
        end
        checks++;
        if (fr_end !== 8'd0) begin
            errors++;
            $display("FAIL m0_frame_before: frame=%0d, required 0", fr_end);
        end
        run_cycles(1);
        checks++;
        if (o_frame !== 8'd1 || o_hpos !== 10'd0 || o_vpos !== 10'd0) begin
            errors++;
            $display("FAIL m0_wrap: frame=%0d hpos=%0d vpos=%0d, required 1/0/0", o_frame, o_hpos, o_vpos);
        end
    endtask

    // Frame 1 must use VGA72; a 1->0->1 pulse inside it is ignored.
    task automatic test_mode1_frame_toggle;
        int len = 1, hs_cnt = 0, hs_first = -1, hs_last = -1;
        int vs_min = 1000, vs_max = -1, fe_cyc = -1, len2 = 0;
        for (int t = 0; t < 1000; t++) begin
            run_cycles(1);
            len++;
            if (o_hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(o_hpos);
                hs_last = int'(o_hpos);
            end
            if (o_hmax === 1'b1) break;
        end
        checks++;
        if (len != 832) begin
            errors++;
            $display("FAIL m1_switch_line_len: %0d clocks, required 832", len);
        end
        checks++;
        if (hs_cnt != 40 || hs_first != 664 || hs_last != 703) begin
            errors++;
            $display("FAIL m1_switch_hsync: %0d clocks %0d..%0d, required 40 at 664..703",
                     hs_cnt, hs_first, hs_last);
        end
        for (int t = 0; t < 440000; t++) begin
            run_cycles(1);
            if (o_hpos == 10'd0) begin
                if (o_vpos == 10'd100) mode = 1'b0;
                if (o_vpos == 10'd150) mode = 1'b1;
            end
            if (o_vsync === 1'b0) begin
                if (int'(o_vpos) < vs_min) vs_min = int'(o_vpos);
                if (int'(o_vpos) > vs_max) vs_max = int'(o_vpos);
            end
            if (o_hmax === 1'b1 && o_vmax === 1'b1) begin
                fe_cyc = cyc;
                break;
            end
        end
        checks++;
        if (fe_cyc != 852639) begin
            errors++;
            $display("FAIL m1_frame_len: frame end at cycle %0d, required 852639", fe_cyc);
        end
        checks++;
        if (vs_min != 489 || vs_max != 491) begin
            errors++;
            $display("FAIL m1_vsync: lines %0d..%0d, required 489..491", vs_min, vs_max);
        end
        for (int t = 0; t < 1000; t++) begin
            run_cycles(1);
            len2++;
            if (o_hmax === 1'b1) break;
        end
        checks++;
        if (len2 != 832 || o_frame !== 8'd2) begin
            errors++;
            $display("FAIL m1_toggle_ignored: line %0d clocks frame %0d, required 832 frame 2", len2, o_frame);
        end
    endtask

    task automatic test_reset_midframe;
        bit found = 0;
        for (int t = 0; t < 260000; t++) begin
            run_cycles(1);
            if (o_hpos == 10'd300 && o_vpos == 10'd300) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midframe_reach: hpos=%0d vpos=%0d, required 300/300", o_hpos, o_vpos);
        end
        do_reset(1'b0, 2);
        run_cycles(1);
        checks++;
        if (o_hpos !== 10'd1 || o_vpos !== 10'd0 || o_frame !== 8'd0) begin
            errors++;
            $display("FAIL midframe_reset: hpos=%0d vpos=%0d frame=%0d, required 1/0/0",
                     o_hpos, o_vpos, o_frame);
        end
    endtask

    task automatic test_mode1_reset;
        int hmax_cyc = -1, hs_cnt = 0, hs_first = -1;
        do_reset(1'b1, 3);
        for (int t = 0; t < 1000; t++) begin
            run_cycles(1);
            if (o_hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(o_hpos);
            end
            if (o_hmax === 1'b1) begin
                hmax_cyc = cyc;
                break;
            end
        end
        checks++;
        if (hmax_cyc != 831) begin
            errors++;
            $display("FAIL m1_reset_line: hmax at cycle %0d, required 831", hmax_cyc);
        end
        checks++;
        if (hs_cnt != 40 || hs_first != 664) begin
            errors++;
            $display("FAIL m1_reset_hsync: %0d clocks from hpos %0d, required 40 from 664", hs_cnt, hs_first);
        end
        run_cycles(2000);
    endtask

    task automatic test_cycle_agreement;
        checks++;
        if (mm_pos != 0) begin
            errors++;
            $display("FAIL cyc_pos: %0d cycles with wrong hpos/vpos, required 0", mm_pos);
        end
        checks++;
        if (mm_flag != 0) begin
            errors++;
            $display("FAIL cyc_flags: %0d cycles with wrong max/blank/visible, required 0", mm_flag);
        end
        checks++;
        if (mm_sync != 0) begin
            errors++;
            $display("FAIL cyc_sync: %0d cycles with wrong hsync/vsync, required 0", mm_sync);
        end
        checks++;
        if (mm_frame != 0) begin
            errors++;
            $display("FAIL cyc_frame: %0d cycles with wrong frame count, required 0", mm_frame);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_line();
        test_mode0_frame_switch();
        test_mode1_frame_toggle();
        test_reset_midframe();
        test_mode1_reset();
        test_cycle_agreement();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
